// File: rtl/replace_num_msg_rx_pkg.sv
// Shared types and defaults for the replace-num UART message parser.
// Holds the frame header value, default field widths and FSM state encodings.
package replace_num_msg_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   localparam int          DEF_ADDR_WIDTH     = 8;
   localparam int          DEF_DATA_WIDTH     = 16;
   localparam logic [7:0]  DEF_HEADER_BYTE    = 8'h52;
   localparam int          DEF_TIMEOUT_CYCLES = 100000;

   // Number of whole bytes needed to carry a field of the given bit width.
   function automatic int field_bytes(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/replace_num_msg_rx_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear, expires after LIMIT of them.
// expire is combinational and suppressed whenever clear is high in the same cycle.
module replace_num_msg_rx_timeout #(
   parameter int LIMIT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam int              CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   assign expire = enable && !clear && (count == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear || !enable || expire) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/replace_num_msg_rx.sv
// Parses header/addr/data/checksum UART frames into one-cycle replace-num writes; wr_en lands
// one clock after the checksum byte. No backpressure: every rx_valid byte is consumed.
module replace_num_msg_rx
   import replace_num_msg_rx_pkg::*;
#(
   parameter int         ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int         DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter logic [7:0] HEADER_BYTE    = DEF_HEADER_BYTE,
   parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_valid,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
   output logic                           wr_en,
   output logic                           busy,
   output logic                           err_checksum,
   output logic                           err_timeout,
   output logic [7:0]                     err_count
);

   localparam int         ADDR_BYTES = field_bytes(ADDR_WIDTH);
   localparam int         DATA_BYTES = field_bytes(DATA_WIDTH);
   localparam int         ASH_W      = ADDR_BYTES * 8;
   localparam int         DSH_W      = DATA_BYTES * 8;
   localparam int         PW         = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
   localparam logic [7:0] DATA_LAST  = 8'(DATA_BYTES - 1);

   state_t            state, state_nxt;
   logic [ASH_W-1:0]  addr_sh, addr_sh_nxt;
   logic [DSH_W-1:0]  data_sh, data_sh_nxt;
   logic [7:0]        csum, csum_nxt;
   logic [7:0]        byte_cnt, byte_cnt_nxt;
   logic [PW-1:0]     wr_packet_nxt;
   logic              wr_en_nxt;
   logic              err_checksum_nxt;
   logic              err_timeout_nxt;
   logic [7:0]        err_count_nxt;
   logic              tmo_expire;

   assign busy = (state != ST_IDLE);

   replace_num_msg_rx_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .enable (busy),
      .clear  (rx_valid),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         addr_sh      <= '0;
         data_sh      <= '0;
         csum         <= '0;
         byte_cnt     <= '0;
         wr_packet    <= '0;
         wr_en        <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_count    <= '0;
      end else begin
         state        <= state_nxt;
         addr_sh      <= addr_sh_nxt;
         data_sh      <= data_sh_nxt;
         csum         <= csum_nxt;
         byte_cnt     <= byte_cnt_nxt;
         wr_packet    <= wr_packet_nxt;
         wr_en        <= wr_en_nxt;
         err_checksum <= err_checksum_nxt;
         err_timeout  <= err_timeout_nxt;
         err_count    <= err_count_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      addr_sh_nxt      = addr_sh;
      data_sh_nxt      = data_sh;
      csum_nxt         = csum;
      byte_cnt_nxt     = byte_cnt;
      wr_packet_nxt    = wr_packet;
      wr_en_nxt        = 1'b0;
      err_checksum_nxt = 1'b0;
      err_timeout_nxt  = 1'b0;
      err_count_nxt    = err_count;

      case (state)
         ST_IDLE: begin
            if (rx_valid && (rx_data == HEADER_BYTE)) begin
               state_nxt    = ST_ADDR;
               addr_sh_nxt  = '0;
               data_sh_nxt  = '0;
               csum_nxt     = '0;
               byte_cnt_nxt = '0;
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               addr_sh_nxt = (addr_sh << 8) | ASH_W'(rx_data);
               csum_nxt    = csum ^ rx_data;
               if (byte_cnt == ADDR_LAST) begin
                  state_nxt    = ST_DATA;
                  byte_cnt_nxt = '0;
               end else begin
                  byte_cnt_nxt = byte_cnt + 8'd1;
               end
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               data_sh_nxt = (data_sh << 8) | DSH_W'(rx_data);
               csum_nxt    = csum ^ rx_data;
               if (byte_cnt == DATA_LAST) begin
                  state_nxt    = ST_CSUM;
                  byte_cnt_nxt = '0;
               end else begin
                  byte_cnt_nxt = byte_cnt + 8'd1;
               end
            end
         end
         ST_CSUM: begin
            if (rx_valid) begin
               state_nxt = ST_IDLE;
               if (rx_data == csum) begin
                  wr_packet_nxt = {addr_sh[ADDR_WIDTH-1:0], data_sh[DATA_WIDTH-1:0]};
                  wr_en_nxt     = 1'b1;
               end else begin
                  err_checksum_nxt = 1'b1;
                  err_count_nxt    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Expiry never coincides with an accepted byte, so it cannot collide with the CSUM outcome.
      if (tmo_expire) begin
         state_nxt       = ST_IDLE;
         err_timeout_nxt = 1'b1;
         err_count_nxt   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_replace_num_msg_rx.sv
// Scoreboard bench for replace_num_msg_rx (A8/D16, short timeout).
module tb_replace_num_msg_rx;

   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [AW+DW-1:0]  wr_packet;
   logic              wr_en;
   logic              busy;
   logic              err_checksum;
   logic              err_timeout;
   logic [7:0]        err_count;

   replace_num_msg_rx #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .HEADER_BYTE    (8'h52),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .wr_packet    (wr_packet),
      .wr_en        (wr_en),
      .busy         (busy),
      .err_checksum (err_checksum),
      .err_timeout  (err_timeout),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW+DW-1:0] pkt;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   wr_seen    = 0;
   int   cs_cycles  = 0;
   int   to_cycles  = 0;
   logic prev_wr    = 1'b0;

   // Write monitor: pops expected {packet, cycle} for every wr_en.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (wr_en) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_wr_en: wr_en=1 wr_packet=%h at cycle %0d, required no write", wr_packet, cyc);
            end else begin
               e = exp_q.pop_front();
               if (wr_packet !== e.pkt || cyc != e.cyc) begin
                  failures++;
                  $display("FAIL wr_packet: got %h at cycle %0d, required %h at cycle %0d", wr_packet, cyc, e.pkt, e.cyc);
               end
            end
            checks++;
            if (prev_wr !== 1'b0) begin
               failures++;
               $display("FAIL wr_spacing: wr_en high on consecutive cycles at cycle %0d", cyc);
            end
            checks++;
            if ((err_checksum | err_timeout) !== 1'b0) begin
               failures++;
               $display("FAIL exclusive: wr_en with err_checksum=%b err_timeout=%b, required both 0", err_checksum, err_timeout);
            end
         end
         if (err_checksum) cs_cycles++;
         if (err_timeout)  to_cycles++;
      end
      prev_wr = wr_en;
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] cs, input bit expect_wr);
      send_byte(8'h52);
      send_byte(a);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
      send_byte(cs);
      if (expect_wr) exp_q.push_back('{pkt: {a, d}, cyc: cyc});
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
      checks++; if (wr_packet !== 24'h0) begin failures++; $display("FAIL reset_wr_packet: got %h required 000000", wr_packet); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if ({err_checksum, err_timeout} !== 2'b00) begin failures++; $display("FAIL reset_err_pulses: got %b required 00", {err_checksum, err_timeout}); end
      checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count: got %h required 00", err_count); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_good_frame;
      int w0 = wr_seen;
      int c0 = cs_cycles;
      send_frame(8'h05, 16'h1234, 8'h23, 1'b1);
      idle(3);
      @(negedge clk);
      checks++; if (wr_seen - w0 != 1) begin failures++; $display("FAIL good_wr_count: got %0d writes required 1", wr_seen - w0); end
      checks++; if (wr_packet !== 24'h051234) begin failures++; $display("FAIL good_wr_packet: got %h required 051234", wr_packet); end
      checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL good_err_count: got %h required 00", err_count); end
      checks++; if (busy !== 1'b0 || cs_cycles != c0) begin failures++; $display("FAIL good_idle: busy=%b cs_pulses=%0d required busy=0 no pulses", busy, cs_cycles - c0); end
   endtask

   task automatic test_bad_checksum;
      int w0 = wr_seen;
      int c0 = cs_cycles;
      send_frame(8'h05, 16'h1234, 8'h24, 1'b0);
      @(negedge clk);
      checks++; if (err_checksum !== 1'b1) begin failures++; $display("FAIL bad_cs_pulse_timing: err_checksum=%b required 1 one clk after checksum byte", err_checksum); end
      idle(3);
      @(negedge clk);
      checks++; if (cs_cycles - c0 != 1) begin failures++; $display("FAIL bad_cs_pulse_width: got %0d cycles required 1", cs_cycles - c0); end
      checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL bad_cs_err_count: got %h required 01", err_count); end
      checks++; if (wr_packet !== 24'h051234 || wr_seen != w0) begin failures++; $display("FAIL bad_cs_no_write: wr_packet=%h writes=%0d required 051234 and 0", wr_packet, wr_seen - w0); end
   endtask

   task automatic test_noise_then_frame;
      int w0 = wr_seen;
      send_byte(8'h00);
      send_byte(8'hFF);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noise_busy: got %b required 0", busy); end
      send_frame(8'h07, 16'hABCD, 8'h61, 1'b1);
      idle(3);
      @(negedge clk);
      checks++; if (wr_packet !== 24'h07ABCD || wr_seen - w0 != 1) begin failures++; $display("FAIL noise_write: wr_packet=%h writes=%0d required 07abcd and 1", wr_packet, wr_seen - w0); end
      checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL noise_err_count: got %h required 01", err_count); end
   endtask

   task automatic test_timeout;
      int t0 = to_cycles;
      int w0;
      send_byte(8'h52);
      send_byte(8'h05);
      rx_valid = 1'b0;
      repeat (TMO - 1) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early: busy=%b err_timeout=%b after %0d stalls required 1 0", busy, err_timeout, TMO - 1); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_fire: err_timeout=%b busy=%b required 1 0", err_timeout, busy); end
      checks++; if (err_count !== 8'h02) begin failures++; $display("FAIL timeout_err_count: got %h required 02", err_count); end
      @(negedge clk);
      checks++; if (to_cycles - t0 != 1) begin failures++; $display("FAIL timeout_pulse_width: got %0d cycles required 1", to_cycles - t0); end

      // Byte arriving on the expiry cycle must win.
      t0 = to_cycles;
      w0 = wr_seen;
      #1;
      send_byte(8'h52);
      send_byte(8'h05);
      rx_valid = 1'b0;
      repeat (TMO - 1) @(posedge clk);
      #1;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h23);
      exp_q.push_back('{pkt: 24'h051234, cyc: cyc});
      idle(3);
      @(negedge clk);
      checks++; if (to_cycles != t0 || err_count !== 8'h02) begin failures++; $display("FAIL timeout_byte_wins: pulses=%0d err_count=%h required 0 and 02", to_cycles - t0, err_count); end
      checks++; if (wr_seen - w0 != 1 || wr_packet !== 24'h051234) begin failures++; $display("FAIL timeout_byte_wins_write: writes=%0d wr_packet=%h required 1 051234", wr_seen - w0, wr_packet); end
   endtask

   task automatic test_reset_midframe;
      int w0;
      #1;
      send_byte(8'h52);
      send_byte(8'h05);
      send_byte(8'h12);
      rx_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || err_count !== 8'h00 || wr_packet !== 24'h0) begin failures++; $display("FAIL midreset_state: busy=%b err_count=%h wr_packet=%h required 0 00 000000", busy, err_count, wr_packet); end
      w0 = wr_seen;
      #1;
      send_byte(8'h34);
      send_byte(8'h23);
      idle(3);
      @(negedge clk);
      checks++; if (wr_seen != w0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_no_write: writes=%0d busy=%b required 0 0", wr_seen - w0, busy); end
      #1;
      send_frame(8'h07, 16'hABCD, 8'h61, 1'b1);
      idle(3);
      @(negedge clk);
      checks++; if (wr_seen - w0 != 1 || wr_packet !== 24'h07ABCD) begin failures++; $display("FAIL midreset_recover: writes=%0d wr_packet=%h required 1 07abcd", wr_seen - w0, wr_packet); end
   endtask

   task automatic test_back_to_back;
      int w0 = wr_seen;
      #1;
      send_frame(8'h05, 16'h1234, 8'h23, 1'b1);
      send_frame(8'h07, 16'hABCD, 8'h61, 1'b1);
      idle(3);
      @(negedge clk);
      checks++; if (wr_seen - w0 != 2) begin failures++; $display("FAIL b2b_writes: got %0d required 2", wr_seen - w0); end
      checks++; if (wr_packet !== 24'h07ABCD || busy !== 1'b0) begin failures++; $display("FAIL b2b_final: wr_packet=%h busy=%b required 07abcd 0", wr_packet, busy); end
   endtask

   task automatic test_err_saturation;
      int c0 = cs_cycles;
      int w0 = wr_seen;
      #1;
      for (int i = 0; i < 256; i++) begin
         send_frame(8'h05, 16'h1234, 8'h24, 1'b0);
         if (i == 253) begin
            checks++; if (err_count !== 8'hFE) begin failures++; $display("FAIL sat_pre: got %h required fe", err_count); end
         end
         if (i == 254) begin
            checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_reach: got %h required ff", err_count); end
         end
      end
      idle(3);
      @(negedge clk);
      checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_hold: got %h required ff", err_count); end
      checks++; if (cs_cycles - c0 != 256 || wr_seen != w0) begin failures++; $display("FAIL sat_pulses: cs=%0d writes=%0d required 256 0", cs_cycles - c0, wr_seen - w0); end
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_bad_checksum;
      test_noise_then_frame;
      test_timeout;
      test_reset_midframe;
      test_back_to_back;
      test_err_saturation;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
